// File: rtl/forwarder_ctrl_pkg.sv
// Shared types and sizing for the forwarder readout path.
package fwd_ctrl_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int OUT_DEPTH  = 4;
  localparam int PTR_W      = $clog2(OUT_DEPTH);
  // One extra bit so the count can represent "full" (OUT_DEPTH) and the
  // credit sum count + in-flight never overflows.
  localparam int CNT_W      = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fwd_state_e;

  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_out_fifo.sv
// Output buffer for the forwarder: OUT_DEPTH-entry first-word-fall-through
// FIFO whose head drives the AXI-Stream master directly.
// AXIS: a beat transfers on a cycle where m_axis_tvalid & m_axis_tready; the
// head entry (tdata/tlast) stays put until that handshake, so a stalled beat
// is held stable. The writer must never push into a full FIFO.
module fwd_out_fifo
  import fwd_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  fwd_entry_t            i_entry,
  output logic [CNT_W-1:0]      o_count,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  fwd_entry_t       r_mem [OUT_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = r_mem[r_rd_ptr].tdata;
  assign m_axis_tlast  = r_mem[r_rd_ptr].tlast;
  assign o_count       = r_count;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/forwarder_ctrl.sv
// Forwarder readout sequencer: reads len words from packetmem and streams
// them on an AXI-Stream master, then pulses forwarder_done.
// Optional statistics counters are built when FORWARDER_CTRL_STATS_EN is defined.
// dbg_state exposes the FSM state for observation.
module forwarder_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready_for_forwarder,
  input  logic [ADDR_WIDTH-1:0] len_to_forwarder,
  output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                  forwarder_rd_en,
  input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
  output logic                  forwarder_done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output fwd_state_e            dbg_state
`ifdef FORWARDER_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_words
`endif
);

  fwd_state_e            r_state;
  fwd_state_e            w_next;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_idle_hold;
  logic [CNT_W-1:0]      w_count;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_last_addr;
  logic                  w_start;
  logic                  w_hs;
  fwd_entry_t            w_push_entry;

  // A read may only be issued if its word is guaranteed a FIFO slot when it
  // returns, counting words already buffered plus the one still in flight.
  assign w_credit_ok = (w_count + CNT_W'(r_inflight)) < CNT_W'(OUT_DEPTH);
  assign w_issue     = (r_state == READ) && w_credit_ok;
  assign w_last_addr = (r_addr == (r_len - ADDR_WIDTH'(1)));
  // The first IDLE cycle after DONE never samples, giving the buffer owner
  // time to switch buffers and update the length.
  assign w_start     = (r_state == IDLE) && !r_idle_hold && ready_for_forwarder;
  assign w_hs        = m_axis_tvalid & m_axis_tready;

  assign forwarder_rd_en   = w_issue;
  assign forwarder_rd_addr = r_addr;
  assign forwarder_done    = (r_state == DONE);
  assign dbg_state         = r_state;

  assign w_push_entry.tlast = r_inflight_last;
  assign w_push_entry.tdata = forwarder_rd_data;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = (len_to_forwarder != '0) ? READ : DONE;
      READ:    if (w_issue && w_last_addr) w_next = DRAIN;
      DRAIN:   if (w_hs && m_axis_tlast) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Length latch, read address counter and in-flight read tracking.
  // The address stops at len-1 rather than stepping past the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len           <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_idle_hold     <= 1'b0;
    end else begin
      if (w_start) begin
        r_len  <= len_to_forwarder;
        r_addr <= '0;
      end else if (w_issue && !w_last_addr) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_addr;
      r_idle_hold     <= (r_state == DONE);
    end
  end

  fwd_out_fifo u_out_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (r_inflight),
    .i_entry       (w_push_entry),
    .o_count       (w_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

`ifdef FORWARDER_CTRL_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_words;

  // Packet and word counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkts  <= '0;
      r_stat_words <= '0;
    end else begin
      if (r_state == DONE) r_stat_pkts  <= r_stat_pkts + 32'd1;
      if (w_hs)            r_stat_words <= r_stat_words + 32'd1;
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_words = r_stat_words;
`endif

endmodule

// File: tb/tb_forwarder_ctrl.sv
// Directed testbench for forwarder_ctrl with a behavioural packetmem model
// and a negedge monitor that records read strobes, beats and done pulses.
module tb_forwarder_ctrl;
  import fwd_ctrl_pkg::*;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ready_for_forwarder;
  logic [AW-1:0] len_to_forwarder;
  logic [AW-1:0] forwarder_rd_addr;
  logic          forwarder_rd_en;
  logic [63:0]   forwarder_rd_data;
  logic          forwarder_done;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  fwd_state_e    dbg_state;
`ifdef FORWARDER_CTRL_STATS_EN
  logic [31:0]   stat_pkts;
  logic [31:0]   stat_words;
`endif

  forwarder_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ready_for_forwarder (ready_for_forwarder),
    .len_to_forwarder    (len_to_forwarder),
    .forwarder_rd_addr   (forwarder_rd_addr),
    .forwarder_rd_en     (forwarder_rd_en),
    .forwarder_rd_data   (forwarder_rd_data),
    .forwarder_done      (forwarder_done),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .dbg_state           (dbg_state)
`ifdef FORWARDER_CTRL_STATS_EN
    ,
    .stat_pkts           (stat_pkts),
    .stat_words          (stat_words)
`endif
  );

  // ---------------- packetmem model: data one cycle after rd_en ----------------
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (forwarder_rd_en) forwarder_rd_data <= mem[forwarder_rd_addr];
  end

  // ---------------- monitor / observation queues ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [AW-1:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] beat_data_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int          done_cyc_q[$];
  int          outstanding = 0;
  int          max_out = 0;
  int          stall_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)
          stall_viol++;
      end
      if (forwarder_rd_en) begin
        rd_addr_q.push_back(forwarder_rd_addr);
        rd_cyc_q.push_back(cyc);
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_data_q.push_back(m_axis_tdata);
        beat_last_q.push_back(m_axis_tlast);
        beat_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (forwarder_done) done_cyc_q.push_back(cyc);
      if (m_axis_tvalid && !m_axis_tready) stall_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    rd_addr_q.delete(); rd_cyc_q.delete(); exp_q.delete();
    beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    done_cyc_q.delete();
    max_out = 0; stall_cnt = 0; stall_viol = 0;
  endtask

  // Drive ready for exactly one sampling edge, starting just after a posedge.
  task automatic start_packet(input int len);
    @(posedge clk); #1;
    len_to_forwarder    = AW'(len);
    ready_for_forwarder = 1'b1;
    @(posedge clk); #1;
    ready_for_forwarder = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_cyc_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ready_for_forwarder = 1'b0; len_to_forwarder = '0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (forwarder_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b exp 0", forwarder_rd_en); end
    checks++; if (forwarder_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", forwarder_done); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b exp 0", m_axis_tlast); end
    checks++; if (forwarder_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d exp 0", forwarder_rd_addr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dbg_state !== IDLE || forwarder_rd_en !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: state %0d rd_en %b exp IDLE/0", dbg_state, forwarder_rd_en); end
  endtask

  task automatic test_len3();
    clear_obs();
    mem[0] = 64'hAAAA_0000_1111_0000; mem[1] = 64'hBBBB_0000_2222_0001; mem[2] = 64'hCCCC_0000_3333_0002;
    m_axis_tready = 1'b1;
    start_packet(3);
    len_to_forwarder = AW'(7); // must be ignored while busy
    wait_done(1, 40);
    checks++; if (rd_addr_q.size() != 3) begin errors++; $display("FAIL len3_rd_count: got %0d exp 3", rd_addr_q.size()); end
    for (int i = 0; i < 3 && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== AW'(i) || rd_cyc_q[i] != rd_cyc_q[0] + i) begin
        errors++; $display("FAIL len3_rd_%0d: addr %0d cyc %0d exp addr %0d cyc %0d", i, rd_addr_q[i], rd_cyc_q[i], i, rd_cyc_q[0] + i);
      end
    end
    checks++; if (beat_data_q.size() != 3) begin errors++; $display("FAIL len3_beat_count: got %0d exp 3", beat_data_q.size()); end
    for (int i = 0; i < 3 && i < beat_data_q.size(); i++) begin
      checks++; if (beat_data_q[i] !== mem[i] || beat_last_q[i] !== (i == 2)) begin
        errors++; $display("FAIL len3_beat_%0d: data %h last %b exp %h %b", i, beat_data_q[i], beat_last_q[i], mem[i], (i == 2));
      end
    end
    if (beat_cyc_q.size() > 0 && rd_cyc_q.size() > 0) begin
      checks++; if (beat_cyc_q[0] != rd_cyc_q[0] + 2) begin errors++; $display("FAIL len3_latency: first beat cyc %0d exp %0d", beat_cyc_q[0], rd_cyc_q[0] + 2); end
    end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL len3_done_count: got %0d exp 1", done_cyc_q.size()); end
    if (done_cyc_q.size() > 0 && beat_cyc_q.size() == 3) begin
      checks++; if (done_cyc_q[0] != beat_cyc_q[2] + 1) begin errors++; $display("FAIL len3_done_cyc: got %0d exp %0d", done_cyc_q[0], beat_cyc_q[2] + 1); end
    end
  endtask

  task automatic test_stall();
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      mem[i] = {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i * 7)};
      exp_q.push_back(mem[i]);
    end
    @(posedge clk); #1;
    len_to_forwarder = AW'(8); ready_for_forwarder = 1'b1; m_axis_tready = pat[0];
    for (int k = 1; k < 200 && done_cyc_q.size() < 1; k++) begin
      @(posedge clk); #1;
      ready_for_forwarder = 1'b0;
      m_axis_tready = pat[k % 4];
    end
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (beat_data_q.size() != 8) begin errors++; $display("FAIL stall_beat_count: got %0d exp 8", beat_data_q.size()); end
    for (int i = 0; i < 8 && i < beat_data_q.size(); i++) begin
      checks++; if (beat_data_q[i] !== exp_q[i] || beat_last_q[i] !== (i == 7)) begin
        errors++; $display("FAIL stall_beat_%0d: data %h last %b exp %h %b", i, beat_data_q[i], beat_last_q[i], exp_q[i], (i == 7));
      end
    end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL stall_seen: got %0d stalled cycles exp >0", stall_cnt); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d violations exp 0", stall_viol); end
    checks++; if (max_out > 4) begin errors++; $display("FAIL stall_credit: max occupancy+inflight %0d exp <=4", max_out); end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL stall_done_count: got %0d exp 1", done_cyc_q.size()); end
  endtask

  task automatic test_len0();
    int start_cyc;
    clear_obs();
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    len_to_forwarder = '0; ready_for_forwarder = 1'b1;
    @(posedge clk); #1;
    ready_for_forwarder = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (beat_data_q.size() != 0 || stall_cnt != 0) begin errors++; $display("FAIL len0_no_beats: got %0d beats exp 0", beat_data_q.size()); end
    checks++; if (rd_addr_q.size() != 0) begin errors++; $display("FAIL len0_no_rd: got %0d reads exp 0", rd_addr_q.size()); end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL len0_done_count: got %0d exp 1", done_cyc_q.size()); end
    if (done_cyc_q.size() > 0) begin
      checks++; if (done_cyc_q[0] < start_cyc + 2 || done_cyc_q[0] > start_cyc + 3) begin
        errors++; $display("FAIL len0_done_cyc: got %0d exp %0d..%0d", done_cyc_q[0], start_cyc + 2, start_cyc + 3);
      end
    end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL len0_idle: got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_len1();
`ifdef FORWARDER_CTRL_STATS_EN
    logic [31:0] p0, w0;
    p0 = stat_pkts; w0 = stat_words;
`endif
    clear_obs();
    mem[0] = 64'h1234_5678_9ABC_DEF0;
    m_axis_tready = 1'b1;
    start_packet(1);
    wait_done(1, 40);
    checks++; if (beat_data_q.size() != 1) begin errors++; $display("FAIL len1_beat_count: got %0d exp 1", beat_data_q.size()); end
    if (beat_data_q.size() > 0) begin
      checks++; if (beat_data_q[0] !== 64'h1234_5678_9ABC_DEF0 || beat_last_q[0] !== 1'b1) begin
        errors++; $display("FAIL len1_beat: data %h last %b exp 123456789abcdef0 1", beat_data_q[0], beat_last_q[0]);
      end
    end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL len1_done_count: got %0d exp 1", done_cyc_q.size()); end
`ifdef FORWARDER_CTRL_STATS_EN
    checks++; if (stat_pkts - p0 !== 32'd1) begin errors++; $display("FAIL len1_stat_pkts: delta %0d exp 1", stat_pkts - p0); end
    checks++; if (stat_words - w0 !== 32'd1) begin errors++; $display("FAIL len1_stat_words: delta %0d exp 1", stat_words - w0); end
`endif
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int i = 0; i < 5; i++) mem[i] = 64'hD000_0000_0000_0000 + 64'(i);
    m_axis_tready = 1'b1;
    start_packet(5);
    for (int k = 0; k < 40 && beat_data_q.size() < 2; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (beat_data_q.size() != 2) begin errors++; $display("FAIL rstmid_two_beats: got %0d exp 2", beat_data_q.size()); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (forwarder_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b exp 0", forwarder_rd_en); end
    checks++; if (forwarder_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b exp 0", forwarder_done); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rstmid_idle: got %0d exp %0d", dbg_state, IDLE); end
    checks++; if (rd_addr_q.size() != 0 || beat_data_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++; $display("FAIL rstmid_quiet: reads %0d beats %0d dones %0d exp 0 0 0", rd_addr_q.size(), beat_data_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic switched;
    clear_obs();
    switched = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 64'hE000_0000_0000_0000 + 64'(i * 3 + 1);
    exp_q.push_back(mem[0]); exp_q.push_back(mem[1]);
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    len_to_forwarder = AW'(2); ready_for_forwarder = 1'b1;
    for (int k = 0; k < 100 && done_cyc_q.size() < 2; k++) begin
      @(posedge clk); #1;
      if (!switched && done_cyc_q.size() == 1) begin len_to_forwarder = AW'(4); switched = 1'b1; end
      if (rd_addr_q.size() >= 3) ready_for_forwarder = 1'b0;
    end
    ready_for_forwarder = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (beat_data_q.size() != 6) begin errors++; $display("FAIL b2b_beat_count: got %0d exp 6", beat_data_q.size()); end
    for (int i = 0; i < 6 && i < beat_data_q.size(); i++) begin
      checks++; if (beat_data_q[i] !== exp_q[i] || beat_last_q[i] !== (i == 1 || i == 5)) begin
        errors++; $display("FAIL b2b_beat_%0d: data %h last %b exp %h %b", i, beat_data_q[i], beat_last_q[i], exp_q[i], (i == 1 || i == 5));
      end
    end
    checks++; if (done_cyc_q.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", done_cyc_q.size()); end
    if (done_cyc_q.size() > 0 && rd_addr_q.size() >= 3) begin
      checks++; if (rd_cyc_q[2] < done_cyc_q[0] + 3 || rd_cyc_q[2] > done_cyc_q[0] + 4 || rd_addr_q[2] !== '0) begin
        errors++; $display("FAIL b2b_gap: second start cyc %0d addr %0d exp cyc %0d..%0d addr 0", rd_cyc_q[2], rd_addr_q[2], done_cyc_q[0] + 3, done_cyc_q[0] + 4);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_len3();
    test_stall();
    test_len0();
    test_len1();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
